// File: rtl/ysyx_22050710_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM (REQ/WAIT/HOLD) with
// branch redirect, in-flight response dropping and a stable instruction buffer.
module ysyx_22050710_ifu #(
  parameter int unsigned          PC_WD    = 32,
  parameter int unsigned          INST_WD  = 32,
  parameter logic [PC_WD-1:0]     RESET_PC = PC_WD'(32'h8000_0000)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_br_sel,
  input  logic [PC_WD-1:0]   i_br_target,
  output logic               o_imem_req_valid,
  input  logic               i_imem_req_ready,
  output logic [PC_WD-1:0]   o_imem_addr,
  input  logic               i_imem_rsp_valid,
  input  logic [INST_WD-1:0] i_imem_rsp_data,
  output logic               o_if_valid,
  input  logic               i_id_ready,
  output logic [PC_WD-1:0]   o_if_pc,
  output logic [INST_WD-1:0] o_if_inst
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PC_WD-1:0]     pc_q, pc_d;
  logic                 drop_q, drop_d;
  logic [INST_WD-1:0]   inst_q, inst_d;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
    end
  end

  // Next-state: a redirect always reloads pc; drop marks a response already in flight
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;

    if (i_br_sel) pc_d = i_br_target;

    case (state_q)
      S_REQ: begin
        if (i_imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = i_br_sel;
        end
      end
      S_WAIT: begin
        if (i_imem_rsp_valid) begin
          if (drop_q || i_br_sel) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = i_imem_rsp_data;
            state_d = S_HOLD;
          end
        end else if (i_br_sel) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_br_sel) begin
          state_d = S_REQ;
        end else if (i_id_ready) begin
          pc_d    = pc_q + PC_WD'(4);
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Handshake outputs are forced low while reset is asserted
  assign o_imem_req_valid = (state_q == S_REQ)  && !i_rst;
  assign o_if_valid       = (state_q == S_HOLD) && !i_rst;
  assign o_imem_addr      = pc_q;
  assign o_if_pc          = pc_q;
  assign o_if_inst        = inst_q;

endmodule

// File: tb/tb_ysyx_22050710_ifu.sv
// Directed bench for ysyx_22050710_ifu: scoreboard of expected (pc, inst)
// pairs pushed when a response is driven and popped when ID sees it.
module tb_ysyx_22050710_ifu;

  localparam int unsigned PC_WD   = 32;
  localparam int unsigned INST_WD = 32;
  localparam logic [31:0] RST_PC  = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  logic               clk;
  logic               rst;
  logic               br_sel;
  logic [PC_WD-1:0]   br_target;
  logic               req_valid;
  logic               req_ready;
  logic [PC_WD-1:0]   imem_addr;
  logic               rsp_valid;
  logic [INST_WD-1:0] rsp_data;
  logic               if_valid;
  logic               id_ready;
  logic [PC_WD-1:0]   if_pc;
  logic [INST_WD-1:0] if_inst;

  int     checks = 0;
  int     errors = 0;
  fetch_t sb_q[$];

  ysyx_22050710_ifu #(
    .PC_WD   (PC_WD),
    .INST_WD (INST_WD),
    .RESET_PC(RST_PC)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_br_sel         (br_sel),
    .i_br_target      (br_target),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_addr      (imem_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .o_if_valid       (if_valid),
    .i_id_ready       (id_ready),
    .o_if_pc          (if_pc),
    .o_if_inst        (if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From REQ at exp_addr: issue, respond with inst, check presentation (ends in HOLD)
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] inst);
    fetch_t f;
    chk("req_valid", 32'(req_valid), 32'd1);
    chk("req_addr", imem_addr, exp_addr);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("wait_req_valid", 32'(req_valid), 32'd0);
    chk("wait_if_valid", 32'(if_valid), 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = inst;
    sb_q.push_back('{pc: exp_addr, inst: inst});
    step();
    rsp_valid = 1'b0;
    chk("hold_if_valid", 32'(if_valid), 32'd1);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      f = sb_q.pop_front();
      chk("sb_pc", if_pc, f.pc);
      chk("sb_inst", if_inst, f.inst);
    end
  endtask

  task automatic release_hold(input logic [31:0] next_addr);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk("next_req_valid", 32'(req_valid), 32'd1);
    chk("next_addr", imem_addr, next_addr);
    chk("next_if_valid", 32'(if_valid), 32'd0);
  endtask

  initial begin
    int vcount;
    rst = 1'b1; br_sel = 1'b0; br_target = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; id_ready = 1'b0;
    step();
    step();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_valid", 32'(req_valid), 32'd1);
    chk("post_rst_addr", imem_addr, RST_PC);
    chk("post_rst_if_valid", 32'(if_valid), 32'd0);
    chk("post_rst_inst", if_inst, 32'd0);

    // First fetch and sequential stream up to 0x8000_0010
    fetch_one(32'h8000_0000, 32'h0000_0013);
    release_hold(32'h8000_0004);
    for (int i = 0; i < 3; i++) begin
      fetch_one(32'h8000_0004 + 32'(i) * 32'd4, 32'h1000_0000 + 32'(i));
      release_hold(32'h8000_0008 + 32'(i) * 32'd4);
    end

    // HOLD stall for 5 cycles
    fetch_one(32'h8000_0010, 32'hdead_beef);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_if_valid", 32'(if_valid), 32'd1);
      chk("stall_pc", if_pc, 32'h8000_0010);
      chk("stall_inst", if_inst, 32'hdead_beef);
    end
    release_hold(32'h8000_0014);

    fetch_one(32'h8000_0014, 32'h2000_0014);
    release_hold(32'h8000_0018);
    fetch_one(32'h8000_0018, 32'h2000_0018);
    release_hold(32'h8000_001c);
    fetch_one(32'h8000_001c, 32'h2000_001c);
    release_hold(32'h8000_0020);

    // Redirect in HOLD with id_ready=1
    fetch_one(32'h8000_0020, 32'h2000_0020);
    id_ready = 1'b1; br_sel = 1'b1; br_target = 32'h8000_0100;
    step();
    id_ready = 1'b0; br_sel = 1'b0;
    chk("hold_br_req_valid", 32'(req_valid), 32'd1);
    chk("hold_br_addr", imem_addr, 32'h8000_0100);
    chk("hold_br_if_valid", 32'(if_valid), 32'd0);

    // Redirect in WAIT, response two cycles later is dropped
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    br_sel = 1'b1; br_target = 32'h8000_0200;
    step();
    br_sel = 1'b0;
    chk("wait_br_req_valid", 32'(req_valid), 32'd0);
    chk("wait_br_if_valid", 32'(if_valid), 32'd0);
    step();
    rsp_valid = 1'b1; rsp_data = 32'hbad0_0001;
    step();
    rsp_valid = 1'b0;
    chk("drop_if_valid", 32'(if_valid), 32'd0);
    chk("drop_req_valid", 32'(req_valid), 32'd1);
    chk("drop_addr", imem_addr, 32'h8000_0200);
    fetch_one(32'h8000_0200, 32'h3000_0200);
    release_hold(32'h8000_0204);

    // Redirect in REQ without ready
    br_sel = 1'b1; br_target = 32'h8000_0300;
    step();
    br_sel = 1'b0;
    chk("req_br_req_valid", 32'(req_valid), 32'd1);
    chk("req_br_addr", imem_addr, 32'h8000_0300);

    // Redirect in REQ with ready: accepted request is dropped
    req_ready = 1'b1; br_sel = 1'b1; br_target = 32'h8000_0400;
    step();
    req_ready = 1'b0; br_sel = 1'b0;
    chk("reqr_br_req_valid", 32'(req_valid), 32'd0);
    rsp_valid = 1'b1; rsp_data = 32'hbad0_0002;
    step();
    rsp_valid = 1'b0;
    chk("reqr_drop_if_valid", 32'(if_valid), 32'd0);
    chk("reqr_drop_req_valid", 32'(req_valid), 32'd1);
    chk("reqr_drop_addr", imem_addr, 32'h8000_0400);

    // Response outside WAIT is ignored
    rsp_valid = 1'b1; rsp_data = 32'hbad0_0003;
    step();
    rsp_valid = 1'b0;
    chk("stray_rsp_req_valid", 32'(req_valid), 32'd1);
    chk("stray_rsp_if_valid", 32'(if_valid), 32'd0);

    // Reset during WAIT, late response ignored
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rst = 1'b1;
    step();
    #1;
    chk("midrst_req_valid", 32'(req_valid), 32'd0);
    chk("midrst_if_valid", 32'(if_valid), 32'd0);
    rst = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'hbad0_0004;
    #1;
    chk("midrst_addr", imem_addr, RST_PC);
    step();
    rsp_valid = 1'b0;
    chk("late_rsp_req_valid", 32'(req_valid), 32'd1);
    chk("late_rsp_if_valid", 32'(if_valid), 32'd0);
    chk("late_rsp_addr", imem_addr, RST_PC);
    chk("late_rsp_inst", if_inst, 32'd0);

    // PC wraparound and unaligned target
    br_sel = 1'b1; br_target = 32'hffff_fffc;
    step();
    br_sel = 1'b0;
    fetch_one(32'hffff_fffc, 32'h4000_0001);
    release_hold(32'h0000_0000);
    br_sel = 1'b1; br_target = 32'h8000_0003;
    step();
    br_sel = 1'b0;
    fetch_one(32'h8000_0003, 32'h4000_0002);
    release_hold(32'h8000_0007);

    // Zero-wait memory throughput: one instruction per 3 cycles
    req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h5000_0005; id_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (if_valid) vcount++;
    end
    req_ready = 1'b0; rsp_valid = 1'b0; id_ready = 1'b0;
    chk("tput_count", 32'(vcount), 32'd3);
    chk("tput_addr", imem_addr, 32'h8000_0013);
    chk("tput_inst", if_inst, 32'h5000_0005);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_ifu.md
YSYX_22050710_IFU -- requirements
Module: ysyx_22050710_ifu

Interface
REQ-001 Parameters SHALL be: PC_WD, default 32, PC width; INST_WD, default 32, instruction width; RESET_PC, default 32'h8000_0000, first fetch address.
REQ-002 Port i_clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 Port i_rst  input  1  synchronous, active-high reset.
REQ-004 Port i_br_sel  input  1  redirect request from the ID-stage branch unit.
REQ-005 Port i_br_target  input  PC_WD  redirect target PC.
REQ-006 Port o_imem_req_valid  output  1  fetch request valid.
REQ-007 Port i_imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 Port o_imem_addr  output  PC_WD  fetch address.
REQ-009 Port i_imem_rsp_valid  input  1  fetch response valid.
REQ-010 Port i_imem_rsp_data  input  INST_WD  fetched instruction.
REQ-011 Port o_if_valid  output  1  instruction valid to ID.
REQ-012 Port i_id_ready  input  1  ID consumes the instruction this cycle.
REQ-013 Port o_if_pc  output  PC_WD  PC of the presented instruction.
REQ-014 Port o_if_inst  output  INST_WD  presented instruction.

Function
REQ-015 The FSM SHALL have exactly three states: REQ (request issue), WAIT (response pending), HOLD (instruction presented).
REQ-016 At most one request SHALL be outstanding; o_imem_req_valid SHALL equal (state==REQ), o_if_valid SHALL equal (state==HOLD), and both SHALL be 0 while i_rst is 1.
REQ-017 o_imem_addr and o_if_pc SHALL both equal the pc register.
REQ-018 REQ: when i_imem_req_ready is 1, the FSM SHALL move to WAIT; otherwise it SHALL stay in REQ.
REQ-019 WAIT: when i_imem_rsp_valid is 1 and the drop flag is 0, the block SHALL latch i_imem_rsp_data into the instruction buffer and move to HOLD.
REQ-020 WAIT: when i_imem_rsp_valid is 1 and the drop flag is 1, the block SHALL discard the data, clear the drop flag and move to REQ.
REQ-021 HOLD: when i_id_ready is 1 and i_br_sel is 0, pc SHALL become pc+4 (modulo 2^PC_WD) and the FSM SHALL move to REQ.
REQ-022 o_if_inst SHALL remain stable for the whole HOLD state.
REQ-023 A redirect (i_br_sel=1) SHALL load pc with i_br_target on the same edge, in any state.
REQ-024 Redirect in HOLD: the buffered instruction SHALL be dropped regardless of i_id_ready, and the FSM SHALL move to REQ.
REQ-025 Redirect in REQ without i_imem_req_ready: the FSM SHALL stay in REQ, and the request SHALL carry the new address from the next cycle (request withdrawal is legal on this interface).
REQ-026 Redirect in REQ with i_imem_req_ready: the FSM SHALL move to WAIT with the drop flag set.
REQ-027 Redirect in WAIT without i_imem_rsp_valid: the drop flag SHALL be set.
REQ-028 Redirect in WAIT with i_imem_rsp_valid: the response SHALL be discarded and the FSM SHALL move to REQ with the drop flag cleared.
REQ-029 i_imem_rsp_valid outside WAIT SHALL be ignored.
REQ-030 Branch target arithmetic SHALL be truncated to PC_WD, with no alignment check.
REQ-031 Latency: with a zero-wait memory, one instruction SHALL be delivered per 3 cycles (REQ, WAIT, HOLD).

Reset
REQ-032 On a clock edge with i_rst=1: pc SHALL be RESET_PC, state SHALL be REQ, the drop flag SHALL be 0 and the instruction buffer SHALL be 0.
REQ-033 After reset: o_imem_req_valid=1, o_imem_addr=RESET_PC, o_if_valid=0, o_if_inst=0 in the first cycle after i_rst falls.
REQ-034 Reset asserted mid-operation in any state SHALL discard all pending work, and a response arriving after reset SHALL be ignored because state is REQ.

Verification
REQ-035 Release reset, memory ready=1, rsp next cycle=32'h00000013, id_ready=1 -> addr 8000_0000, o_if_valid=1 with inst 00000013 three cycles later, next addr 8000_0004.
REQ-036 HOLD at pc 8000_0010, id_ready=0 for 5 cycles -> o_if_valid, o_if_pc, o_if_inst stable; then id_ready=1 -> next request addr 8000_0014.
REQ-037 HOLD at 8000_0020, id_ready=1, br_sel=1, target 8000_0100 -> next request addr 8000_0100, no fetch of 8000_0024.
REQ-038 WAIT, br_sel=1 target 8000_0200, rsp arrives 2 cycles later -> response discarded, o_if_valid stays 0, next request addr 8000_0200.
REQ-039 REQ with req_ready=0, br_sel=1 target 8000_0300 -> next cycle o_imem_addr=8000_0300, o_imem_req_valid=1.
REQ-040 i_rst=1 during WAIT, then rsp_valid=1 one cycle after release -> response ignored, request reissued at RESET_PC.
